// File: rtl/rv_regfile_immgen_mem.sv
// rtl/rv_regfile_immgen_mem.sv - RV32I register file, immediate generator and unified word memory
// Storage-and-decode slice of the multicycle datapath; every output is combinational from inputs and state.
module rv_regfile_immgen_mem #(
   parameter int          MEM_ADDR_WIDTH = 10,
   parameter logic [31:0] SP_INIT        = 32'h1001_03FC,
   parameter logic [31:0] GP_INIT        = 32'h1001_8000
) (
   input  logic                      iCLK,
   input  logic                      iRST,
   input  logic                      iRegWrite,
   input  logic [4:0]                iReadReg1,
   input  logic [4:0]                iReadReg2,
   input  logic [4:0]                iWriteReg,
   input  logic [31:0]               iWriteData,
   input  logic [4:0]                iRegDispSelect,
   output logic [31:0]               oReadData1,
   output logic [31:0]               oReadData2,
   output logic [31:0]               oRegDisp,
   input  logic [31:0]               iInstrucao,
   output logic [31:0]               oImm,
   input  logic [MEM_ADDR_WIDTH-1:0] iAdress,
   input  logic                      iMemRead,
   input  logic                      iMemWrite,
   input  logic [31:0]               iMemWriteData,
   output logic [31:0]               oMemReadData
);

   localparam int MEM_DEPTH = 2 ** (MEM_ADDR_WIDTH - 2);

   logic [31:0] r_regs [32] = '{2: SP_INIT, 3: GP_INIT, default: 32'h0};
   logic [31:0] r_mem [MEM_DEPTH] = '{default: 32'h0};

   logic [MEM_ADDR_WIDTH-3:0] w_word_idx;
   logic [1:0]                w_unused_byte_off;
   logic [6:0]                w_opcode;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= (i == 2) ? SP_INIT : (i == 3) ? GP_INIT : 32'h0;
         end
      end else if (iRegWrite && (iWriteReg != 5'd0)) begin
         r_regs[iWriteReg] <= iWriteData;
      end
   end

   assign oReadData1 = (iReadReg1 == 5'd0)      ? 32'h0 : r_regs[iReadReg1];
   assign oReadData2 = (iReadReg2 == 5'd0)      ? 32'h0 : r_regs[iReadReg2];
   assign oRegDisp   = (iRegDispSelect == 5'd0) ? 32'h0 : r_regs[iRegDispSelect];

   assign w_opcode = iInstrucao[6:0];

   always_comb begin
      oImm = 32'h0;
      case (w_opcode)
         7'b0000011, 7'b0010011, 7'b1100111:
            oImm = {{20{iInstrucao[31]}}, iInstrucao[31:20]};
         7'b0100011:
            oImm = {{20{iInstrucao[31]}}, iInstrucao[31:25], iInstrucao[11:7]};
         7'b1100011:
            oImm = {{19{iInstrucao[31]}}, iInstrucao[31], iInstrucao[7],
                    iInstrucao[30:25], iInstrucao[11:8], 1'b0};
         7'b0110111, 7'b0010111:
            oImm = {iInstrucao[31:12], 12'h000};
         7'b1101111:
            oImm = {{11{iInstrucao[31]}}, iInstrucao[31], iInstrucao[19:12],
                    iInstrucao[20], iInstrucao[30:21], 1'b0};
         default:
            oImm = 32'h0;
      endcase
   end

   // Byte offset is dropped: misaligned accesses land on the containing word.
   assign w_word_idx        = iAdress[MEM_ADDR_WIDTH-1:2];
   assign w_unused_byte_off = iAdress[1:0];

   // Memory is never cleared by reset so it can map onto block RAM.
   always_ff @(posedge iCLK) begin
      if (!iRST && iMemWrite) begin
         r_mem[w_word_idx] <= iMemWriteData;
      end
   end

   assign oMemReadData = iMemRead ? r_mem[w_word_idx] : 32'h0;

endmodule

// File: tb/tb_rv_regfile_immgen_mem.sv
// tb/tb_rv_regfile_immgen_mem.sv - directed and randomized checks against an array-based reference model
module tb_rv_regfile_immgen_mem;

   logic        iCLK = 1'b0;
   logic        iRST = 1'b0;
   logic        iRegWrite = 1'b0;
   logic [4:0]  iReadReg1 = '0, iReadReg2 = '0, iWriteReg = '0, iRegDispSelect = '0;
   logic [31:0] iWriteData = '0, iInstrucao = '0, iMemWriteData = '0;
   logic [9:0]  iAdress = '0;
   logic        iMemRead = 1'b0, iMemWrite = 1'b0;
   logic [31:0] oReadData1, oReadData2, oRegDisp, oImm, oMemReadData;

   int tests = 0;
   int fails = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_mem  [256];

   rv_regfile_immgen_mem dut (
      .iCLK(iCLK), .iRST(iRST), .iRegWrite(iRegWrite),
      .iReadReg1(iReadReg1), .iReadReg2(iReadReg2), .iWriteReg(iWriteReg),
      .iWriteData(iWriteData), .iRegDispSelect(iRegDispSelect),
      .oReadData1(oReadData1), .oReadData2(oReadData2), .oRegDisp(oRegDisp),
      .iInstrucao(iInstrucao), .oImm(oImm),
      .iAdress(iAdress), .iMemRead(iMemRead), .iMemWrite(iMemWrite),
      .iMemWriteData(iMemWriteData), .oMemReadData(oMemReadData)
   );

   always #5 iCLK = ~iCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_regs[2] = 32'h1001_03FC;
      m_regs[3] = 32'h1001_8000;
   endtask

   function automatic int sext(input int v, input int bits);
      return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
   endfunction

   function automatic logic [31:0] ref_imm(input logic [31:0] inst);
      int v;
      case (inst[6:0])
         7'h03, 7'h13, 7'h67: v = sext(int'(inst[31:20]), 12);
         7'h23:               v = sext(int'({inst[31:25], inst[11:7]}), 12);
         7'h63:               v = 2 * sext(int'({inst[31], inst[7], inst[30:25], inst[11:8]}), 12);
         7'h37, 7'h17:        v = int'(inst & 32'hFFFF_F000);
         7'h6F:               v = 2 * sext(int'({inst[31], inst[19:12], inst[20], inst[30:21]}), 20);
         default:             v = 0;
      endcase
      return 32'(v);
   endfunction

   task automatic clock_edge();
      logic        rst, rw, mw;
      logic [4:0]  wr;
      logic [31:0] wd, md;
      int          idx;
      rst = iRST; rw = iRegWrite; wr = iWriteReg; wd = iWriteData;
      mw = iMemWrite; md = iMemWriteData; idx = int'(iAdress) / 4;
      @(posedge iCLK);
      #1;
      if (rst) model_reset();
      else begin
         if (rw && wr != 0) m_regs[wr] = wd;
         if (mw) m_mem[idx] = md;
      end
   endtask

   function automatic logic [31:0] exp_reg(input logic [4:0] idx);
      return (idx == 0) ? 32'h0 : m_regs[idx];
   endfunction

   initial begin
      logic [31:0] imm_in  [6] = '{32'hFFF0_0093, 32'hFE11_2E23, 32'hFE00_0EE3,
                                   32'h1234_50B7, 32'h0080_00EF, 32'h0020_80B3};
      logic [31:0] imm_exp [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFFC,
                                   32'h1234_5000, 32'h0000_0008, 32'h0000_0000};
      logic [6:0]  ops [10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

      model_reset();
      for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;

      #1;
      iRegDispSelect = 5'd2; #1; check("powerup_x2", oRegDisp, 32'h1001_03FC);
      iRegDispSelect = 5'd3; #1; check("powerup_x3", oRegDisp, 32'h1001_8000);

      // 1: reset and display port
      iRST = 1'b1; clock_edge(); iRST = 1'b0;
      iRegDispSelect = 5'd2; #1; check("rst_disp_x2", oRegDisp, 32'h1001_03FC);
      iRegDispSelect = 5'd3; #1; check("rst_disp_x3", oRegDisp, 32'h1001_8000);
      iRegDispSelect = 5'd5; #1; check("rst_disp_x5", oRegDisp, 32'h0);

      // 2: no bypass before the edge, x0 stays zero
      iRegWrite = 1'b1; iWriteReg = 5'd5; iWriteData = 32'hDEAD_BEEF; iReadReg1 = 5'd5;
      #1; check("rd1_before_edge", oReadData1, 32'h0);
      clock_edge();
      check("rd1_after_edge", oReadData1, 32'hDEAD_BEEF);
      iWriteReg = 5'd0; iWriteData = 32'h1234; iReadReg2 = 5'd0;
      clock_edge();
      check("x0_read", oReadData2, 32'h0);
      iRegWrite = 1'b0;

      // 3: immediate decode
      for (int i = 0; i < 6; i++) begin
         iInstrucao = imm_in[i]; #1;
         check($sformatf("imm_%h", imm_in[i]), oImm, imm_exp[i]);
      end

      // 4: memory write, misaligned read, read gating
      iAdress = 10'h010; iMemWriteData = 32'hCAFE_F00D; iMemWrite = 1'b1;
      clock_edge(); iMemWrite = 1'b0;
      iMemRead = 1'b1; iAdress = 10'h010; #1; check("mem_rd_010", oMemReadData, 32'hCAFE_F00D);
      iAdress = 10'h013; #1; check("mem_rd_013", oMemReadData, 32'hCAFE_F00D);
      iMemRead = 1'b0; #1; check("mem_rd_gated", oMemReadData, 32'h0);

      // 5: reset blocks memory writes but clears registers
      iAdress = 10'h000; iMemWriteData = 32'h0000_0013; iMemWrite = 1'b1;
      clock_edge();
      iRST = 1'b1; iMemWriteData = 32'hFFFF_FFFF;
      clock_edge();
      iRST = 1'b0; iMemWrite = 1'b0; iMemRead = 1'b1; iReadReg1 = 5'd5;
      #1; check("mem_kept_in_rst", oMemReadData, 32'h0000_0013);
      check("x5_after_rst", oReadData1, 32'h0);

      // 6: simultaneous register and top-word memory write
      iRegWrite = 1'b1; iWriteReg = 5'd7; iWriteData = 32'h7777_0007; iReadReg2 = 5'd7;
      iMemWrite = 1'b1; iAdress = 10'h3FC; iMemWriteData = 32'hA5A5_5A5A;
      #1; check("mem_top_old", oMemReadData, 32'h0);
      clock_edge();
      iRegWrite = 1'b0; iMemWrite = 1'b0;
      #1; check("x7_commit", oReadData2, 32'h7777_0007);
      check("mem_top_commit", oMemReadData, 32'hA5A5_5A5A);

      // Randomized phase against the reference model
      for (int n = 0; n < 300; n++) begin
         iRST       = ($urandom_range(0, 39) == 0);
         iRegWrite  = $urandom_range(0, 1);
         iWriteReg  = 5'($urandom_range(0, 31));
         iWriteData = $urandom;
         iReadReg1  = 5'($urandom_range(0, 31));
         iReadReg2  = 5'($urandom_range(0, 31));
         iRegDispSelect = 5'($urandom_range(0, 31));
         iInstrucao = $urandom;
         iInstrucao[6:0] = ops[$urandom_range(0, 9)];
         if ($urandom_range(0, 1) == 1) iAdress = 10'($urandom_range(0, 63));
         else                           iAdress = 10'($urandom_range(0, 1023));
         iMemRead      = $urandom_range(0, 3) != 0;
         iMemWrite     = $urandom_range(0, 1);
         iMemWriteData = $urandom;
         #1;
         check("rnd_rd1",  oReadData1, exp_reg(iReadReg1));
         check("rnd_rd2",  oReadData2, exp_reg(iReadReg2));
         check("rnd_disp", oRegDisp,   exp_reg(iRegDispSelect));
         check("rnd_imm",  oImm,       ref_imm(iInstrucao));
         check("rnd_mem",  oMemReadData, iMemRead ? m_mem[int'(iAdress) / 4] : 32'h0);
         clock_edge();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
